// File: rtl/pe_packetizer_pkg.sv
// Shared packet-field constants, type codes and packet struct for the PE packetizer.
// Field layout (default widths): [46] type, [45:43] dest, [42:40] source, [39:0] payload.
// Imported by the packetizer top; no logic, so no latency or backpressure of its own.
package pe_packetizer_pkg;

    localparam int TYPE_BIT  = 46;
    localparam int DEST_MSB  = 45;
    localparam int DEST_LSB  = 43;
    localparam int SRC_MSB   = 42;
    localparam int SRC_LSB   = 40;
    localparam int PAYLOAD_W = 40;

    localparam logic PKT_PIXEL  = 1'b1;
    localparam logic PKT_FILTER = 1'b0;

    typedef struct packed {
        logic                 typ;
        logic [2:0]           dest;
        logic [2:0]           src;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

endpackage

// File: rtl/pe_packetizer_pkt_fifo.sv
// Packet queue: circular buffer with a registered occupancy count and wrapping pointers.
// Latency: a word written at edge N is visible at out_data after edge N when the queue was empty.
// Backpressure: full is registered; the writer must not push while full, pop holds out_data otherwise.
module pkt_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pe_packetizer.sv
// Packetizer: merges pixel and filter words into headed packets queued for one downstream port.
// Latency: 1 cycle from accept to pkt_valid on an empty queue. Optional macro: PKTZ_RR_ARB_EN (round-robin).
// Backpressure: input ready depends only on registered full and arbitration, never on pkt_ready.
module pe_packetizer
    import pe_packetizer_pkg::*;
#(
    parameter int         DWIDTH     = 8,
    parameter int         PWIDTH     = 47,
    parameter logic [2:0] SRC_ADDR   = 3'b000,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [5*DWIDTH-1:0]   pix_data,
    input  logic [2:0]            pix_dest,
    input  logic                  filt_valid,
    output logic                  filt_ready,
    input  logic [3*DWIDTH-1:0]   filt_data,
    input  logic [2:0]            filt_dest,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [PWIDTH-1:0]     pkt_data
);

    localparam int HDR_W  = TYPE_BIT - SRC_LSB + 1;
    localparam int FPAD_W = PWIDTH - HDR_W - 3*DWIDTH;

    logic              full;
    logic              fifo_valid;
    logic              prefer_pix;
    logic              grant_pix;
    logic              grant_filt;
    logic              pix_acc;
    logic              filt_acc;
    logic [PWIDTH-1:0] pkt_in;

    assign grant_pix  = pix_valid && (!filt_valid || prefer_pix);
    assign grant_filt = filt_valid && !grant_pix;

    // No handshake may complete while reset is asserted.
    assign pix_ready  = !rst && !full && grant_pix;
    assign filt_ready = !rst && !full && grant_filt;
    assign pix_acc    = pix_valid && pix_ready;
    assign filt_acc   = filt_valid && filt_ready;
    assign pkt_valid  = fifo_valid && !rst;

`ifdef PKTZ_RR_ARB_EN
    logic last_pix;

    assign prefer_pix = !last_pix;

    // Remember the last source served so a conflict goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pix <= 1'b0;
        end else if (pix_acc) begin
            last_pix <= 1'b1;
        end else if (filt_acc) begin
            last_pix <= 1'b0;
        end
    end
`else
    assign prefer_pix = 1'b1;
`endif

    // Build the header plus payload for whichever source holds the grant.
    always_comb begin
        if (grant_pix) begin
            pkt_in = {PKT_PIXEL, pix_dest, SRC_ADDR, pix_data};
        end else begin
            pkt_in = {PKT_FILTER, filt_dest, SRC_ADDR, {FPAD_W{1'b0}}, filt_data};
        end
    end

    pkt_fifo #(
        .WIDTH (PWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pix_acc || filt_acc),
        .in_data   (pkt_in),
        .full      (full),
        .out_valid (fifo_valid),
        .out_ready (pkt_ready && !rst),
        .out_data  (pkt_data)
    );

endmodule

// File: tb/tb_pe_packetizer.sv
// Bench for pe_packetizer: directed scenarios followed by randomized traffic and resets.
// Expected packets come from a queue-based reference model of arbitration and the output queue.
// Honors PKTZ_RR_ARB_EN the same way the design does.
module tb_pe_packetizer;
    import pe_packetizer_pkg::*;

    localparam int         DW  = 8;
    localparam int         PW  = 47;
    localparam logic [2:0] SRC = 3'b011;
    localparam int         FD  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid, pix_ready;
    logic [5*DW-1:0] pix_data;
    logic [2:0]    pix_dest;
    logic          filt_valid, filt_ready;
    logic [3*DW-1:0] filt_data;
    logic [2:0]    filt_dest;
    logic          pkt_valid, pkt_ready;
    logic [PW-1:0] pkt_data;

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] exp_q[$];
    bit            m_last_pix;

    pe_packetizer #(
        .DWIDTH     (DW),
        .PWIDTH     (PW),
        .SRC_ADDR   (SRC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_dest   (pix_dest),
        .filt_valid (filt_valid),
        .filt_ready (filt_ready),
        .filt_data  (filt_data),
        .filt_dest  (filt_dest),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pix(input logic [2:0] d, input logic [39:0] p);
        pkt_t k;
        k.typ = PKT_PIXEL; k.dest = d; k.src = SRC; k.payload = p;
        return k;
    endfunction

    function automatic logic [PW-1:0] mk_filt(input logic [2:0] d, input logic [23:0] w);
        pkt_t k;
        k.typ = PKT_FILTER; k.dest = d; k.src = SRC; k.payload = {16'h0000, w};
        return k;
    endfunction

    // Reference model and monitor: evaluated mid-cycle, when inputs and DUT outputs are settled.
    always @(negedge clk) begin
        logic e_full, pref, e_gp, e_gf;
        if (rst) begin
            chk("rst_pix_ready",  PW'(pix_ready),  '0);
            chk("rst_filt_ready", PW'(filt_ready), '0);
            chk("rst_pkt_valid",  PW'(pkt_valid),  '0);
            exp_q.delete();
            m_last_pix = 1'b0;
        end else begin
            e_full = (exp_q.size() == FD);
`ifdef PKTZ_RR_ARB_EN
            pref = !m_last_pix;
`else
            pref = 1'b1;
`endif
            e_gp = pix_valid && (!filt_valid || pref);
            e_gf = filt_valid && !e_gp;
            chk("pix_ready",  PW'(pix_ready),  PW'(!e_full && e_gp));
            chk("filt_ready", PW'(filt_ready), PW'(!e_full && e_gf));
            chk("pkt_valid",  PW'(pkt_valid),  PW'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("pkt_data", pkt_data, exp_q[0]);
            if (exp_q.size() != 0 && pkt_ready) void'(exp_q.pop_front());
            if (!e_full && e_gp) begin
                exp_q.push_back(mk_pix(pix_dest, pix_data));
                m_last_pix = 1'b1;
            end else if (!e_full && e_gf) begin
                exp_q.push_back(mk_filt(filt_dest, filt_data));
                m_last_pix = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        filt_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        logic [3:0]    g;
        logic [3:0]    g_exp;
        logic [PW-1:0] held;
        rst = 1'b1; pix_valid = 1'b0; filt_valid = 1'b0; pkt_ready = 1'b1;
        pix_data = '0; pix_dest = '0; filt_data = '0; filt_dest = '0;
        repeat (3) cyc();
        rst = 1'b0;
        idle(2);

        // Single pixel packet, one-cycle latency.
        pix_valid = 1'b1; pix_data = 40'h0102030405; pix_dest = 3'b101;
        cyc();
        pix_valid = 1'b0;
        @(negedge clk);
        chk("pix_latency_valid", PW'(pkt_valid), PW'(1));
        chk("pix_packet", pkt_data, {1'b1, 3'b101, SRC, 40'h0102030405});
        idle(2);

        // Filter packet with zeroed upper payload.
        filt_valid = 1'b1; filt_data = 24'hAABBCC; filt_dest = 3'b010;
        cyc();
        filt_valid = 1'b0;
        @(negedge clk);
        chk("filt_type", PW'(pkt_data[TYPE_BIT]), PW'(0));
        chk("filt_dest", PW'(pkt_data[DEST_MSB:DEST_LSB]), PW'(3'b010));
        chk("filt_src",  PW'(pkt_data[SRC_MSB:SRC_LSB]), PW'(SRC));
        chk("filt_pad",  PW'(pkt_data[39:24]), '0);
        chk("filt_wts",  PW'(pkt_data[23:0]), PW'(24'hAABBCC));
        idle(2);

        // Both sources valid for four cycles with the output draining.
        pix_valid = 1'b1; filt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_data = 40'({$urandom(), $urandom()}); pix_dest = 3'($urandom());
            filt_data = 24'($urandom()); filt_dest = 3'($urandom());
            @(negedge clk);
            g[i] = pix_ready;
            cyc();
        end
`ifdef PKTZ_RR_ARB_EN
        g_exp = 4'b0101;
`else
        g_exp = 4'b1111;
`endif
        chk("grant_order", PW'(g), PW'(g_exp));
        idle(3);

        // Stalled output: three offers, two accepted, head held stable.
        pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = 40'h1000000000 + 40'(i); pix_dest = 3'(i);
            cyc();
        end
        pix_valid = 1'b1; pix_data = 40'hDEAD;
        @(negedge clk);
        chk("full_pix_ready", PW'(pix_ready), '0);
        held = pkt_data;
        cyc();
        @(negedge clk);
        chk("head_stable", pkt_data, held);
        chk("head_first", pkt_data, mk_pix(3'd0, 40'h1000000000));
        // Full queue, pop and pending pixel: push follows one cycle later.
        pkt_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("push_after_pop", PW'(pix_ready), PW'(1));
        idle(4);

        // Reset with two queued packets discards them.
        pkt_ready = 1'b0;
        pix_valid = 1'b1; pix_data = 40'h55; cyc();
        pix_data = 40'h66; cyc();
        pix_valid = 1'b0;
        rst = 1'b1; cyc();
        rst = 1'b0; pkt_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", PW'(pkt_valid), '0);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            pix_valid  = 1'($urandom());
            filt_valid = 1'($urandom());
            pkt_ready  = ($urandom_range(0, 3) != 0);
            pix_data   = 40'({$urandom(), $urandom()});
            pix_dest   = 3'($urandom());
            filt_data  = 24'($urandom());
            filt_dest  = 3'($urandom());
            cyc();
        end
        rst = 1'b0; pkt_ready = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
- REQ-001 Parameter DWIDTH, default 8, is the width of one data element.
- REQ-002 Parameter PWIDTH, default 47, is the packet width and SHALL equal 5*DWIDTH+7.
- REQ-003 Parameter SRC_ADDR, default 3'b000, is this node's 3-bit source address.
- REQ-004 Parameter FIFO_DEPTH, default 2, is the output queue depth, minimum 2.
- REQ-005 clk, input, 1: single clock; all state updates on posedge.
- REQ-006 rst, input, 1: reset, synchronous and active-high.
- REQ-007 pix_valid, input, 1: pixel word offered.
- REQ-008 pix_ready, output, 1: pixel word accepted this cycle when high with pix_valid.
- REQ-009 pix_data, input, 5*DWIDTH: five pixels.
- REQ-010 pix_dest, input, 3: destination address for the pixel packet.
- REQ-011 filt_valid, input, 1: filter word offered.
- REQ-012 filt_ready, output, 1: filter word accepted when high with filt_valid.
- REQ-013 filt_data, input, 3*DWIDTH: three filter weights.
- REQ-014 filt_dest, input, 3: destination address for the filter packet.
- REQ-015 pkt_valid, output, 1: packet available at the head of the queue.
- REQ-016 pkt_ready, input, 1: downstream consumes the packet when high with pkt_valid.
- REQ-017 pkt_data, output, PWIDTH: the head packet.

Function
- REQ-018 Packet format: [PWIDTH-1] type (1 = pixel, 0 = filter), [45:43] dest, [42:40] SRC_ADDR, [39:0] payload.
- REQ-019 A pixel payload SHALL be pix_data unmodified in [39:0].
- REQ-020 A filter payload SHALL be filt_data in [23:0], with [39:24] forced to zero.
- REQ-021 The block SHALL accept at most one input per cycle; grant goes to the single valid source, or to the arbitration winner when both are valid.
- REQ-022 pix_ready = !full && grant_pix; filt_ready = !full && grant_filt; full is the registered count == FIFO_DEPTH; pkt_ready SHALL NOT feed into either ready signal.
- REQ-023 A packet accepted at edge N SHALL appear on pkt_valid/pkt_data after edge N if the queue was empty, giving 1-cycle latency.
- REQ-024 Queue order is FIFO; on a simultaneous push and pop the count is unchanged and both take effect.
- REQ-025 While pkt_valid && !pkt_ready, pkt_data SHALL be held stable.
- REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; a 0..FIFO_DEPTH count register tracks occupancy.
- REQ-027 Empty SHALL force pkt_valid=0, and pkt_data SHALL then be don't-care.

Reset
- REQ-028 With rst high at a posedge: count=0, both pointers=0, pkt_valid=0, last_grant=filter, and pix_ready/filt_ready=0 during that cycle.
- REQ-029 Reset mid-transfer SHALL discard all queued packets; no handshake completes in a cycle where rst is high.

Configuration
- REQ-030 With PKTZ_RR_ARB_EN defined, a both-valid conflict SHALL be resolved round-robin against last_grant, which updates on every accept.
- REQ-031 Without PKTZ_RR_ARB_EN, pixel SHALL have fixed priority and last_grant is unused.

Structure
- REQ-032 The shared package SHALL hold the packet-field constants (TYPE_BIT, DEST_MSB/LSB, SRC_MSB/LSB), the PKT_PIXEL/PKT_FILTER type values and a pkt_t packed struct.
- REQ-033 The queue SHALL be a sub-module named pkt_fifo, parameterised by width and depth.

Verification
- REQ-034 Reset, then a single pixel with pix_data=40'h0102030405 and dest=3'b101 -> one cycle later pkt_data={1'b1,3'b101,SRC_ADDR,40'h0102030405} and pkt_valid=1.
- REQ-035 Filter filt_data=24'hAABBCC with dest=3'b010 -> pkt_data[46]=0, [45:43]=010, [39:24]=0, [23:0]=AABBCC.
- REQ-036 Both sources valid for 4 cycles with pkt_ready=1: with the macro, grant order is pix, filt, pix, filt; without the macro, all four grants go to pix.
- REQ-037 pkt_ready=0 with 3 offers -> 2 accepted, then both ready signals 0, and pkt_data stable; raising pkt_ready drains the queue in order.
- REQ-038 Full queue with pkt_ready=1 and pix_valid=1 -> the pop completes, no push occurs that cycle (ready was 0), and the push follows next cycle.
- REQ-039 rst asserted with 2 queued packets -> pkt_valid=0 the next cycle, and no stale packet appears afterwards.
